// File: rtl/mac_seq_pkg.sv
// rtl/mac_seq_pkg.sv - shared types and constants for the matrix-vector sequencer
package mac_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    WAIT_LOAD = 3'd2,
    RUN       = 3'd3,
    FLUSH     = 3'd4,
    DRAIN     = 3'd5,
    DONE      = 3'd6
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_MACS   = 8;
  localparam int DEF_VEC_LEN    = 8;
  localparam int DEF_ACC_WIDTH  = 24;
  localparam int DEF_MAC_LAT    = 1;

  // Last skewed step index: row NUM_MACS-1 finishes VEC_LEN-1 steps after it starts.
  function automatic int step_last_f(input int vec_len, input int num_macs);
    return vec_len + num_macs - 2;
  endfunction

  // One cycle for the final FIFO read to reach the MAC, then MAC_LAT for it to land.
  function automatic int flush_cyc_f(input int mac_lat);
    return 1 + mac_lat;
  endfunction

  localparam int STEP_LAST = step_last_f(DEF_VEC_LEN, DEF_NUM_MACS);
  localparam int FLUSH_CYC = flush_cyc_f(DEF_MAC_LAT);

endpackage

// File: rtl/matvec_sequencer_skew.sv
// rtl/matvec_sequencer_skew.sv - per-row pop window decode and stall check
//
// Purpose: for skew step t, decide which FIFOs must pop and whether any of
// them is empty (in which case the whole step is withheld).
// Ports:
//   t            in   current step index
//   fifo_a_empty in   per-row A FIFO empty flags
//   fifo_b_empty in   B FIFO empty flag
//   req_a        out  row i pops when i <= t < i+VEC_LEN
//   req_b        out  B pops when t < VEC_LEN
//   stall        out  some required FIFO is empty
module seq_skew_gen #(
  parameter int NUM_MACS = 8,
  parameter int VEC_LEN  = 8,
  parameter int T_W      = 4
) (
  input  logic [T_W-1:0]      t,
  input  logic [NUM_MACS-1:0] fifo_a_empty,
  input  logic                fifo_b_empty,
  output logic [NUM_MACS-1:0] req_a,
  output logic                req_b,
  output logic                stall
);

  logic [31:0] tv;

  always_comb begin
    tv    = 32'(t);
    req_a = '0;
    for (int i = 0; i < NUM_MACS; i++) begin
      req_a[i] = (tv >= 32'(i)) && (tv < 32'(i + VEC_LEN));
    end
    req_b = (tv < 32'(VEC_LEN));
    stall = (|(req_a & fifo_a_empty)) | (req_b & fifo_b_empty);
  end

endmodule

// File: rtl/matvec_sequencer.sv
// rtl/matvec_sequencer.sv - sequences one skewed 8x8 matrix-vector multiply
//
// Purpose: clear the MACs, wait for the FIFOs to be loaded, pop them with a
// one-cycle-per-row skew (stalling whole steps on empty), flush the MAC
// pipeline, snapshot the accumulators and stream them out with valid/ready.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               job start pulse (IDLE/DONE only)
//   load_done           FIFOs loaded (sampled in WAIT_LOAD only)
//   fifo_a_empty/rden   per-row A FIFO status / pop
//   fifo_b_empty/rden   B FIFO status / pop
//   mac_clr, mac_en     MAC clear and per-MAC accumulate enable
//   mac_result          packed accumulators, MAC i at [i*ACC_WIDTH +: ACC_WIDTH]
//   res_data/idx/valid  result stream, res_ready from the consumer
//   busy, done          activity and completion levels
//   state_out           current state encoding
module matvec_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_MACS   = DEF_NUM_MACS,
  parameter int VEC_LEN    = DEF_VEC_LEN,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int MAC_LAT    = DEF_MAC_LAT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          load_done,
  input  logic [NUM_MACS-1:0]           fifo_a_empty,
  output logic [NUM_MACS-1:0]           fifo_a_rden,
  input  logic                          fifo_b_empty,
  output logic                          fifo_b_rden,
  output logic                          mac_clr,
  output logic [NUM_MACS-1:0]           mac_en,
  input  logic [NUM_MACS*ACC_WIDTH-1:0] mac_result,
  output logic [ACC_WIDTH-1:0]          res_data,
  output logic [$clog2(NUM_MACS)-1:0]   res_idx,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic                          busy,
  output logic                          done,
  output logic [2:0]                    state_out
);

  localparam int T_W       = $clog2(VEC_LEN + NUM_MACS);
  localparam int K_W       = $clog2(NUM_MACS) + 1;
  localparam int IDX_W     = $clog2(NUM_MACS);
  localparam int STEP_LST  = step_last_f(VEC_LEN, NUM_MACS);
  localparam int FLUSH_N   = flush_cyc_f(MAC_LAT);
  localparam int F_W       = $clog2(FLUSH_N) + 1;
  // t counts steps already issued; T_END means the last step is on the pop lines.
  localparam logic [T_W-1:0] T_END  = T_W'(STEP_LST + 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_MACS - 1);
  localparam logic [F_W-1:0] F_LAST = F_W'(FLUSH_N - 1);

  // A dot product of DATA_WIDTH operands must at least hold one full product.
  if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_acc_width_chk
    $error("ACC_WIDTH narrower than one DATA_WIDTH product");
  end

  state_t                 state, state_n;
  logic [T_W-1:0]         t, t_n;
  logic [K_W-1:0]         k, k_n, k_inc;
  logic [F_W-1:0]         fcnt, fcnt_n;
  logic [NUM_MACS-1:0]    rden_a_n;
  logic                   rden_b_n;
  logic                   clr_n, valid_n, busy_n, done_n, snap_take;
  logic [ACC_WIDTH-1:0]   data_n;
  logic [IDX_W-1:0]       idx_n;
  logic [ACC_WIDTH-1:0]   snap [NUM_MACS];

  logic [NUM_MACS-1:0]    req_a;
  logic                   req_b, stall;

  seq_skew_gen #(
    .NUM_MACS (NUM_MACS),
    .VEC_LEN  (VEC_LEN),
    .T_W      (T_W)
  ) u_skew (
    .t            (t),
    .fifo_a_empty (fifo_a_empty),
    .fifo_b_empty (fifo_b_empty),
    .req_a        (req_a),
    .req_b        (req_b),
    .stall        (stall)
  );

  assign k_inc     = k + K_W'(1);
  assign state_out = state;

  // Pops are registered, so step t is decided on the edge that starts the
  // cycle its rden is visible: step 0 is decided on the WAIT_LOAD->RUN edge and
  // RUN ends once the last step's pop has been presented.
  always_comb begin
    state_n   = state;
    t_n       = t;
    k_n       = k;
    fcnt_n    = fcnt;
    rden_a_n  = '0;
    rden_b_n  = 1'b0;
    valid_n   = 1'b0;
    data_n    = res_data;
    idx_n     = res_idx;
    snap_take = 1'b0;

    case (state)
      IDLE: begin
        if (start) state_n = CLEAR;
      end
      CLEAR: begin
        t_n     = '0;
        state_n = WAIT_LOAD;
      end
      WAIT_LOAD: begin
        if (load_done) begin
          state_n = RUN;
          if (!stall) begin
            rden_a_n = req_a;
            rden_b_n = req_b;
            t_n      = t + T_W'(1);
          end
        end
      end
      RUN: begin
        if (t == T_END) begin
          state_n = FLUSH;
          fcnt_n  = '0;
        end else if (!stall) begin
          rden_a_n = req_a;
          rden_b_n = req_b;
          t_n      = t + T_W'(1);
        end
      end
      FLUSH: begin
        if (fcnt == F_LAST) begin
          // Row 0 is forwarded straight from the accumulators so the first beat
          // is ready in the cycle DRAIN is entered.
          state_n   = DRAIN;
          snap_take = 1'b1;
          k_n       = '0;
          valid_n   = 1'b1;
          data_n    = mac_result[ACC_WIDTH-1:0];
          idx_n     = '0;
        end else begin
          fcnt_n = fcnt + F_W'(1);
        end
      end
      DRAIN: begin
        valid_n = 1'b1;
        if (res_valid && res_ready) begin
          if (k == K_LAST) begin
            state_n = DONE;
            valid_n = 1'b0;
          end else begin
            k_n    = k_inc;
            data_n = snap[k_inc[IDX_W-1:0]];
            idx_n  = k_inc[IDX_W-1:0];
          end
        end
      end
      DONE: begin
        if (start) state_n = CLEAR;
      end
      default: state_n = IDLE;
    endcase

    clr_n  = (state_n == CLEAR);
    busy_n = (state_n != IDLE) && (state_n != DONE);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      t           <= '0;
      k           <= '0;
      fcnt        <= '0;
      fifo_a_rden <= '0;
      fifo_b_rden <= 1'b0;
      mac_en      <= '0;
      mac_clr     <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_idx     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      t           <= t_n;
      k           <= k_n;
      fcnt        <= fcnt_n;
      fifo_a_rden <= rden_a_n;
      fifo_b_rden <= rden_b_n;
      mac_en      <= fifo_a_rden;   // FIFO data arrives one cycle after the pop
      mac_clr     <= clr_n;
      res_valid   <= valid_n;
      res_data    <= data_n;
      res_idx     <= idx_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_MACS; i++) snap[i] <= '0;
    end else if (snap_take) begin
      for (int i = 0; i < NUM_MACS; i++) snap[i] <= mac_result[i*ACC_WIDTH +: ACC_WIDTH];
    end
  end

endmodule
